// File: rtl/fpcmp_pkg.sv
// Shared definitions for the fpcmp comparator and its two-requester arbiter.
package fpcmp_pkg;

  // Comparison predicates (3-bit). Codes 110/111 are reserved and give z=0, flags=0.
  localparam logic [2:0] PRED_EQ  = 3'b000;
  localparam logic [2:0] PRED_NE  = 3'b001;
  localparam logic [2:0] PRED_LE  = 3'b010;
  localparam logic [2:0] PRED_LT  = 3'b011;
  localparam logic [2:0] PRED_ULE = 3'b100;
  localparam logic [2:0] PRED_ULT = 3'b101;

  // Bit positions inside the {V,I,O,U,X} flag vector.
  localparam int FLAG_V = 4;
  localparam int FLAG_I = 3;
  localparam int FLAG_O = 2;
  localparam int FLAG_U = 1;
  localparam int FLAG_X = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/fpcmp.sv
// Single-precision floating-point comparator. Single-cycle, so stall is tied low;
// the arbiter still honours stall so a multi-cycle variant can drop in.
module fpcmp
  import fpcmp_pkg::*;
(
  input  logic        run,
  input  logic [2:0]  pred,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic        z,
  output logic [4:0]  flags,
  output logic        stall
);

  logic x_nan, y_nan, x_snan, y_snan, unord, both_zero;
  logic eq, lt, z_raw, v_raw, pred_ok;

  assign x_nan     = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  assign y_nan     = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
  assign x_snan    = x_nan && !x[22];
  assign y_snan    = y_nan && !y[22];
  assign unord     = x_nan || y_nan;
  assign both_zero = (x[30:0] == 31'd0) && (y[30:0] == 31'd0);

  // Ordered relations; +0 and -0 compare equal.
  assign eq = !unord && (both_zero || (x == y));
  assign lt = !unord && !both_zero &&
              ((x[31] != y[31]) ? x[31] :
               (x[31] ? (x[30:0] > y[30:0]) : (x[30:0] < y[30:0])));

  // Predicate decode: unordered operands satisfy NE/ULE/ULT only.
  always_comb begin
    z_raw   = 1'b0;
    pred_ok = 1'b1;
    case (pred)
      PRED_EQ:  z_raw = eq;
      PRED_NE:  z_raw = !eq;
      PRED_LE:  z_raw = eq || lt;
      PRED_LT:  z_raw = lt;
      PRED_ULE: z_raw = unord || eq || lt;
      PRED_ULT: z_raw = unord || lt;
      default:  pred_ok = 1'b0;
    endcase
  end

  // Invalid: any signalling NaN, or any NaN under a relational predicate.
  assign v_raw = pred_ok && (x_snan || y_snan ||
                 (unord && (pred != PRED_EQ) && (pred != PRED_NE)));

  // Only V can arise from a compare; the remaining flags stay clear.
  always_comb begin
    flags         = 5'd0;
    flags[FLAG_V] = run && v_raw;
  end

  assign z     = run && z_raw;
  assign stall = 1'b0;

endmodule

// File: rtl/fpcmp_arb.sv
// Two-requester front end sharing one fpcmp: arbitrate, register operands,
// compare for one cycle, return the result to the owner, accumulate sticky flags.
module fpcmp_arb
  import fpcmp_pkg::*;
#(
  parameter bit RR_EN     = 1'b1,
  parameter bit INIT_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [2:0]  req0_pred,
  input  logic [31:0] req0_x,
  input  logic [31:0] req0_y,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp0_z,
  output logic [4:0]  rsp0_flags,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [2:0]  req1_pred,
  input  logic [31:0] req1_x,
  input  logic [31:0] req1_y,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic        rsp1_z,
  output logic [4:0]  rsp1_flags,
  input  logic        sticky_clr,
  output logic [4:0]  sticky_flags,
  output logic        busy
);

  state_t      state;
  logic        ptr, owner;
  logic [2:0]  pred_r;
  logic [31:0] x_r, y_r;
  logic        grant0, grant1, run, cmp_z, cmp_stall, done;
  logic [4:0]  cmp_flags;

  // Grant: requester 0 wins unless requester 1 also competes and the pointer favours it.
  always_comb begin
    grant0 = req0_valid && (!req1_valid || !RR_EN || (ptr == 1'b0));
    grant1 = req1_valid && !grant0;
  end

  assign req0_ready = (state == ST_IDLE) && grant0;
  assign req1_ready = (state == ST_IDLE) && grant1;
  assign run        = (state == ST_EXEC);
  assign busy       = (state != ST_IDLE);
  assign done       = owner ? rsp1_ready : rsp0_ready;

  fpcmp u_cmp (
    .run   (run),
    .pred  (pred_r),
    .x     (x_r),
    .y     (y_r),
    .z     (cmp_z),
    .flags (cmp_flags),
    .stall (cmp_stall)
  );

  // Control FSM with operand capture, owner tracking and per-requester result regs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      ptr        <= INIT_PRIO;
      owner      <= 1'b0;
      pred_r     <= 3'd0;
      x_r        <= 32'd0;
      y_r        <= 32'd0;
      rsp0_valid <= 1'b0;
      rsp0_z     <= 1'b0;
      rsp0_flags <= 5'd0;
      rsp1_valid <= 1'b0;
      rsp1_z     <= 1'b0;
      rsp1_flags <= 5'd0;
    end else begin
      case (state)
        ST_IDLE: if (grant0 || grant1) begin
          owner  <= grant1;
          pred_r <= grant1 ? req1_pred : req0_pred;
          x_r    <= grant1 ? req1_x    : req0_x;
          y_r    <= grant1 ? req1_y    : req0_y;
          // Favour the requester that just lost out (or was absent).
          if (RR_EN) ptr <= !grant1;
          state  <= ST_EXEC;
        end
        ST_EXEC: if (!cmp_stall) begin
          if (owner) begin
            rsp1_valid <= 1'b1;
            rsp1_z     <= cmp_z;
            rsp1_flags <= cmp_flags;
          end else begin
            rsp0_valid <= 1'b1;
            rsp0_z     <= cmp_z;
            rsp0_flags <= cmp_flags;
          end
          state <= ST_RESP;
        end
        ST_RESP: if (done) begin
          rsp0_valid <= 1'b0;
          rsp1_valid <= 1'b0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Sticky exception register; a flag update in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sticky_flags <= 5'd0;
    else if (run && !cmp_stall)
      sticky_flags <= sticky_clr ? cmp_flags : (sticky_flags | cmp_flags);
    else if (sticky_clr)
      sticky_flags <= 5'd0;
  end

endmodule

// File: tb/tb_fpcmp_arb.sv
// Directed plus randomized bench for fpcmp_arb with a transaction-level reference model.
module tb_fpcmp_arb;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req0_valid = 0, req0_ready, rsp0_valid, rsp0_ready = 0, rsp0_z;
  logic [2:0]  req0_pred = 0;
  logic [31:0] req0_x = 0, req0_y = 0;
  logic [4:0]  rsp0_flags;
  logic        req1_valid = 0, req1_ready, rsp1_valid, rsp1_ready = 0, rsp1_z;
  logic [2:0]  req1_pred = 0;
  logic [31:0] req1_x = 0, req1_y = 0;
  logic [4:0]  rsp1_flags;
  logic        sticky_clr = 0, busy;
  logic [4:0]  sticky_flags;

  always #5 clk = ~clk;

  fpcmp_arb #(.RR_EN(1'b1), .INIT_PRIO(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_pred(req0_pred),
    .req0_x(req0_x), .req0_y(req0_y), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_z(rsp0_z), .rsp0_flags(rsp0_flags),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_pred(req1_pred),
    .req1_x(req1_x), .req1_y(req1_y), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_z(rsp1_z), .rsp1_flags(rsp1_flags),
    .sticky_clr(sticky_clr), .sticky_flags(sticky_flags), .busy(busy)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  logic [4:0]  sticky_m = 0;
  bit          ptr_m = 0, pend0 = 0, pend1 = 0;
  logic [2:0]  p0, p1;
  logic [31:0] a0, b0, a1, b1;

  function automatic bit is_nan(input logic [31:0] f);
    return (f[30:23] == 8'hFF) && (f[22:0] != 0);
  endfunction

  // Maps a non-NaN float to an unsigned key whose ordering matches numeric order.
  function automatic logic [31:0] okey(input logic [31:0] f);
    if (f[30:0] == 0) return 32'h8000_0000;
    return f[31] ? ~f : (f | 32'h8000_0000);
  endfunction

  // Returns {z, flags[4:0]}.
  function automatic logic [5:0] model(input logic [2:0] p, input logic [31:0] a, input logic [31:0] b);
    bit un, e, l, z, v, snan;
    un   = is_nan(a) || is_nan(b);
    snan = (is_nan(a) && !a[22]) || (is_nan(b) && !b[22]);
    e    = !un && (okey(a) == okey(b));
    l    = !un && (okey(a) <  okey(b));
    case (p)
      3'd0: z = e;
      3'd1: z = !e;
      3'd2: z = e || l;
      3'd3: z = l;
      3'd4: z = un || e || l;
      3'd5: z = un || l;
      default: z = 0;
    endcase
    v = (p <= 3'd5) && (snan || (un && p >= 3'd2));
    return {z, v, 4'b0000};
  endfunction

  // ---------------- requester helpers ----------------
  task automatic arm(input int n, input logic [2:0] p, input logic [31:0] a, input logic [31:0] b);
    if (n == 0) begin req0_pred = p; req0_x = a; req0_y = b; p0 = p; a0 = a; b0 = b; end
    else        begin req1_pred = p; req1_x = a; req1_y = b; p1 = p; a1 = a; b1 = b; end
  endtask

  task automatic start(input int n, input logic [2:0] p, input logic [31:0] a, input logic [31:0] b);
    arm(n, p, a, b);
    if (n == 0) begin req0_valid = 1; pend0 = 1; end
    else        begin req1_valid = 1; pend1 = 1; end
  endtask

  // One full accept/exec/response sequence. Entered and left just after a rising edge.
  task automatic step_txn(input int hold, input bit clr_exec, input bit inj);
    int w;
    logic [5:0] e;
    @(negedge clk);
    if (pend0 && pend1) w = ptr_m ? 1 : 0;
    else w = pend0 ? 0 : 1;
    chk("ready0_idle", req0_ready, w == 0);
    chk("ready1_idle", req1_ready, w == 1);
    chk("busy_idle", busy, 0);
    @(posedge clk); #1;
    if (w == 0) begin req0_valid = 0; pend0 = 0; e = model(p0, a0, b0); end
    else        begin req1_valid = 0; pend1 = 0; e = model(p1, a1, b1); end
    ptr_m = (w == 0);
    if (clr_exec) sticky_clr = 1;
    if (inj) begin
      if (w == 0) begin req1_valid = 1; pend1 = 1; end
      else        begin req0_valid = 1; pend0 = 1; end
    end
    @(negedge clk);
    chk("rsp0_valid_exec", rsp0_valid, 0);
    chk("rsp1_valid_exec", rsp1_valid, 0);
    chk("busy_exec", busy, 1);
    chk("ready_exec", {req0_ready, req1_ready}, 0);
    @(posedge clk); #1;
    sticky_clr = 0;
    sticky_m = clr_exec ? e[4:0] : (sticky_m | e[4:0]);
    for (int k = 0; k <= hold; k++) begin
      @(negedge clk);
      chk("rsp0_valid", rsp0_valid, w == 0);
      chk("rsp1_valid", rsp1_valid, w == 1);
      chk("rsp_z", (w == 0) ? rsp0_z : rsp1_z, e[5]);
      chk("rsp_flags", (w == 0) ? rsp0_flags : rsp1_flags, e[4:0]);
      chk("ready_resp", {req0_ready, req1_ready}, 0);
      chk("sticky", sticky_flags, sticky_m);
    end
    if (w == 0) rsp0_ready = 1; else rsp1_ready = 1;
    @(posedge clk); #1;
    rsp0_ready = 0; rsp1_ready = 0;
  endtask

  task automatic clr_idle();
    sticky_clr = 1;
    @(posedge clk); #1;
    sticky_clr = 0;
    sticky_m = 0;
    chk("sticky_clr_idle", sticky_flags, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk(tag, {rsp0_valid, rsp0_z, rsp0_flags, rsp1_valid, rsp1_z, rsp1_flags, sticky_flags, busy,
              req0_ready, req1_ready}, 0);
  endtask

  // Requester-side protocol monitor: valid must not drop before ready.
  bit pv0 = 0, pr0 = 0, pv1 = 0, pr1 = 0;
  always @(posedge clk) begin
    if (rst_n && ((pv0 && !pr0 && !req0_valid) || (pv1 && !pr1 && !req1_valid))) begin
      n_chk++;
      $error("FAIL proto: valid dropped before ready (req0 %b req1 %b)", req0_valid, req1_valid);
    end
    pv0 = req0_valid; pr0 = req0_ready; pv1 = req1_valid; pr1 = req1_ready;
  end

  logic [31:0] pool [12] = '{32'h0000_0000, 32'h8000_0000, 32'h3F80_0000, 32'hBF80_0000,
                             32'h4000_0000, 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000,
                             32'h7F80_0001, 32'hFFA0_0000, 32'h0000_0001, 32'h8000_0001};

  function automatic logic [31:0] pick();
    if ($urandom_range(0, 3) == 0) return $urandom;
    return pool[$urandom_range(0, 11)];
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("reset_state");
    rst_n = 1;
    @(posedge clk); #1;

    // 1: basic EQ, latency t -> t+2
    start(0, 3'd0, 32'h3F80_0000, 32'h3F80_0000);
    step_txn(0, 0, 0);

    // 2: simultaneous requests, round-robin alternation
    start(0, 3'd3, 32'h3F80_0000, 32'h4000_0000);
    start(1, 3'd2, 32'h4000_0000, 32'h3F80_0000);
    step_txn(0, 0, 0);
    step_txn(0, 0, 0);
    start(0, 3'd3, 32'h4000_0000, 32'h3F80_0000);
    start(1, 3'd2, 32'h3F80_0000, 32'h4000_0000);
    step_txn(0, 0, 0);
    step_txn(0, 0, 0);

    // 3: quiet NaN under EQ and ULT
    start(1, 3'd0, 32'h7FC0_0000, 32'h0);
    step_txn(0, 0, 0);
    start(1, 3'd5, 32'h7FC0_0000, 32'h0);
    step_txn(0, 0, 0);
    chk("sticky_t3", sticky_flags, 5'b10000);

    // 4: signalling NaN, clear while idle, clear racing an EXEC update
    start(0, 3'd1, 32'h7F80_0001, 32'h0);
    step_txn(0, 0, 0);
    clr_idle();
    start(0, 3'd1, 32'h7F80_0001, 32'h3F80_0000);
    step_txn(0, 1, 0);
    chk("sticky_set_wins", sticky_flags, 5'b10000);

    // 5: +0 vs -0, response back-pressure with a competing request
    arm(1, 3'd4, 32'h0000_0001, 32'h8000_0001);
    start(0, 3'd0, 32'h0000_0000, 32'h8000_0000);
    step_txn(5, 0, 1);
    step_txn(0, 0, 0);

    // 6: reset pulse during EXEC aborts the operation
    start(0, 3'd3, 32'h3F80_0000, 32'h4000_0000);
    @(negedge clk);
    chk("ready0_t6", req0_ready, 1);
    @(posedge clk); #1;
    req0_valid = 0; pend0 = 0;
    rst_n = 0;
    #1;
    chk_reset_vals("abort_reset");
    ptr_m = 0; sticky_m = 0;
    @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("no_rsp_after_abort", {rsp0_valid, rsp1_valid, busy}, 0);
    end
    @(posedge clk); #1;
    start(1, 3'd3, 32'hBF80_0000, 32'h3F80_0000);
    step_txn(0, 0, 0);

    // Randomized traffic
    for (int it = 0; it < 60; it++) begin
      int m;
      m = $urandom_range(1, 3);
      if (m[0]) start(0, 3'($urandom_range(0, 7)), pick(), pick());
      if (m[1]) start(1, 3'($urandom_range(0, 7)), pick(), pick());
      while (pend0 || pend1)
        step_txn($urandom_range(0, 2), ($urandom_range(0, 5) == 0), 0);
      if ($urandom_range(0, 4) == 0) clr_idle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
